seq_chunk_adder: RTL

//   Multi-cycle, parametrised-width binary adder that adds CHUNK bits per clock

---
 rtl/seq_chunk_adder_pkg.sv | 16 +
 rtl/seq_chunk_adder_chunk_adder.sv | 24 ++
 rtl/seq_chunk_adder.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: FSM encoding and width helper shared by the chunked adder.
package seq_chunk_adder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // clog2 clamped to at least 1 so a single-chunk counter still has a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry slice; exports carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_o
);
    logic [CHUNK:0] c;

    always_comb begin
        c = '0;
        c[0] = cin_i;
        for (int i = 0; i < CHUNK; i++)
            c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign s_o     = a_i ^ b_i ^ c[CHUNK-1:0];
    assign cout_o  = c[CHUNK];
    assign c_msb_o = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder, CHUNK bits per clock with a registered
// inter-chunk carry and a start/busy/done handshake.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2_min1(NCHUNK);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, s_q, sum_q, s_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q, ovf_q, busy_q, done_q, last;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout, slice_cmsb;

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (c_q),
        .s_o    (slice_s),
        .cout_o (slice_cout),
        .c_msb_o(slice_cmsb)
    );

    // new slice enters at the top so after NCHUNK shifts chunk 0 sits at bit 0
    assign s_d  = WIDTH'({slice_s, s_q} >> CHUNK);
    assign last = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    c_q     <= carry_in;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    s_q <= s_d;
                    c_q <= slice_cout;
                    if (last) begin
                        sum_q   <= s_d;
                        cout_q  <= slice_cout;
                        ovf_q   <= slice_cout ^ slice_cmsb;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
